period_sequencer: RTL

PERIOD_SEQUENCER -- requirements
Module: period_sequencer

---
 rtl/period_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/period_sequencer.sv
// Period sequencer for a count-the-symbols game: IDLE -> PRE -> GAME -> ANSWER -> POST -> PRE.
// Each period counts down whole seconds on tick1Hz. The player's count is collected in ANSWER
// and scored on exit. A correct answer advances the level when POST ends.
// Optional feature: define PERIOD_SEQ_STRIKE_EN to return to IDLE after three wrong answers.
module period_sequencer (
    input  logic       Clk100M,
    input  logic       resetN,
    input  logic       tick1Hz,
    input  logic       start,
    input  logic       userUp,
    input  logic       userDown,
    input  logic [5:0] targetCount,
    output logic       pre,
    output logic       game,
    output logic       answer,
    output logic       post,
    output logic       startGen,
    output logic       stopGen,
    output logic [3:0] secsLeft,
    output logic [5:0] userCount,
    output logic [3:0] level,
    output logic       correct,
    output logic       levelComplete
);

    typedef enum logic [2:0] {StIdle, StPre, StGame, StAnswer, StPost} state_e;

    state_e     state_q, state_d;
    logic [3:0] secs_q, secs_d;
    logic [3:0] level_q, level_d;
    logic [5:0] count_q, count_d, count_upd;
    logic       correct_q, correct_d;
    logic [3:0] game_secs;
    logic       period_end;
`ifdef PERIOD_SEQ_STRIKE_EN
    logic [1:0] strikes_q, strikes_d;
`endif

    // GAME gets one second shorter per level, never below 4 s
    always_comb begin
        game_secs = 4'd4;
        if (level_q < 4'd8) game_secs = 4'd12 - level_q;
    end

    // Saturating player count step; up and down in the same cycle cancel
    always_comb begin
        count_upd = count_q;
        if (userUp && !userDown && count_q != 6'd63) begin
            count_upd = count_q + 6'd1;
        end else if (userDown && !userUp && count_q != 6'd0) begin
            count_upd = count_q - 6'd1;
        end
    end

    // Next-state, countdown, scoring and level logic
    always_comb begin
        state_d    = state_q;
        secs_d     = secs_q;
        level_d    = level_q;
        count_d    = count_q;
        correct_d  = correct_q;
`ifdef PERIOD_SEQ_STRIKE_EN
        strikes_d  = strikes_q;
`endif
        period_end = tick1Hz && (secs_q == 4'd1);

        // Count update lands on every ANSWER cycle, including the exit cycle
        if (state_q == StAnswer) count_d = count_upd;

        if (state_q != StIdle && tick1Hz && !period_end) secs_d = secs_q - 4'd1;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPre;
                    secs_d  = 4'd3;
                end
            end
            StPre: begin
                if (period_end) begin
                    state_d = StGame;
                    secs_d  = game_secs;
                end
            end
            StGame: begin
                if (period_end) begin
                    state_d = StAnswer;
                    secs_d  = 4'd5;
                    count_d = '0;
                end
            end
            StAnswer: begin
                if (period_end) begin
                    state_d   = StPost;
                    secs_d    = 4'd3;
                    // Score the count as it stands after this cycle's pulse
                    correct_d = (count_upd == targetCount);
                end
            end
            StPost: begin
                if (period_end) begin
                    state_d = StPre;
                    secs_d  = 4'd3;
                    if (correct_q) begin
                        if (level_q != 4'd15) level_d = level_q + 4'd1;
                    end
`ifdef PERIOD_SEQ_STRIKE_EN
                    else if (strikes_q == 2'd2) begin
                        state_d   = StIdle;
                        secs_d    = '0;
                        level_d   = '0;
                        strikes_d = '0;
                    end else begin
                        strikes_d = strikes_q + 2'd1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counters and registered outputs; reset clears everything at once
    always_ff @(posedge Clk100M or negedge resetN) begin
        if (!resetN) begin
            state_q       <= StIdle;
            secs_q        <= '0;
            level_q       <= '0;
            count_q       <= '0;
            correct_q     <= 1'b0;
            pre           <= 1'b0;
            game          <= 1'b0;
            answer        <= 1'b0;
            post          <= 1'b0;
            startGen      <= 1'b0;
            stopGen       <= 1'b0;
            levelComplete <= 1'b0;
`ifdef PERIOD_SEQ_STRIKE_EN
            strikes_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            secs_q        <= secs_d;
            level_q       <= level_d;
            count_q       <= count_d;
            correct_q     <= correct_d;
            pre           <= (state_d == StPre);
            game          <= (state_d == StGame);
            answer        <= (state_d == StAnswer);
            post          <= (state_d == StPost);
            startGen      <= (state_q == StPre) && (state_d == StGame);
            stopGen       <= (state_q == StGame) && (state_d == StAnswer);
            levelComplete <= (state_q == StPost) && (state_d == StPre) && correct_q;
`ifdef PERIOD_SEQ_STRIKE_EN
            strikes_q     <= strikes_d;
`endif
        end
    end

    assign secsLeft  = secs_q;
    assign userCount = count_q;
    assign level     = level_q;
    assign correct   = correct_q;

endmodule
